reg_bank16: RTL and testbench

REG_BANK16 -- requirements
Module: reg_bank16

---
 rtl/reg_bank16_pkg.sv | 17 +
 rtl/dec4_to_16.sv | 23 ++
 rtl/reg_bank16.sv | 132 +++++++++++++
 tb/tb_reg_bank16.sv | 192 +++++++++++++++++++
 4 files changed

// File: rtl/reg_bank16_pkg.sv
// Shared definitions for the 16-entry register bank and the datapath read muxes.
//   DATA_WIDTH : default register/port data width
//   NUM_REGS   : register count (fixed at 16)
//   ADDR_WIDTH : register index width
//   state_t    : clear-controller state encoding
package reg_bank16_pkg;

  localparam int unsigned DATA_WIDTH = 32;
  localparam int unsigned NUM_REGS   = 16;
  localparam int unsigned ADDR_WIDTH = 4;

  typedef enum logic {
    IDLE  = 1'b0,
    CLEAR = 1'b1
  } state_t;

endpackage

// File: rtl/dec4_to_16.sv
// One-hot strobe decoder: a 4-bit index plus enable yields N one-hot strobes.
//   idx    : register index
//   en     : enable; all strobes low when 0
//   strobe : one-hot strobe vector
module dec4_to_16
  import reg_bank16_pkg::*;
#(
  parameter int unsigned N = NUM_REGS
) (
  input  logic [ADDR_WIDTH-1:0] idx,
  input  logic                  en,
  output logic [N-1:0]          strobe
);

  // Combinational decode of idx into a single strobe bit.
  always_comb begin
    strobe = '0;
    if (en) begin
      strobe[idx] = 1'b1;
    end
  end

endmodule

// File: rtl/reg_bank16.sv
// Flip-flop register bank, r0 hard-wired to zero, with a sequential clear engine.
//   clk, rst        : clock, asynchronous active-high reset
//   we/waddr/wdata  : synchronous write port (dropped while busy)
//   clr_req         : start a clear of r1..r15, one register per cycle
//   busy            : high while a clear sequence runs
//   clr_done        : one-cycle pulse after the last register is cleared
//   q0..q15         : concurrently readable register contents
module reg_bank16
  import reg_bank16_pkg::*;
#(
  parameter int unsigned WIDTH = DATA_WIDTH,
  parameter int unsigned NREG  = NUM_REGS
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  we,
  input  logic [ADDR_WIDTH-1:0] waddr,
  input  logic [WIDTH-1:0]      wdata,
  input  logic                  clr_req,
  output logic                  busy,
  output logic                  clr_done,
  output logic [WIDTH-1:0]      q0,
  output logic [WIDTH-1:0]      q1,
  output logic [WIDTH-1:0]      q2,
  output logic [WIDTH-1:0]      q3,
  output logic [WIDTH-1:0]      q4,
  output logic [WIDTH-1:0]      q5,
  output logic [WIDTH-1:0]      q6,
  output logic [WIDTH-1:0]      q7,
  output logic [WIDTH-1:0]      q8,
  output logic [WIDTH-1:0]      q9,
  output logic [WIDTH-1:0]      q10,
  output logic [WIDTH-1:0]      q11,
  output logic [WIDTH-1:0]      q12,
  output logic [WIDTH-1:0]      q13,
  output logic [WIDTH-1:0]      q14,
  output logic [WIDTH-1:0]      q15
);

  state_t                state;
  logic [ADDR_WIDTH-1:0] cidx;
  logic [NREG-1:0]       wstb;
  logic [NREG-1:0]       cstb;
  logic                  wr_en;
  logic                  clr_en;
  logic                  unused_strobes;
  logic [WIDTH-1:0]      r [1:NREG-1];

  // Writes are accepted only while the clear engine is idle.
  assign wr_en  = we & ~busy;
  assign clr_en = (state == CLEAR);

  dec4_to_16 #(.N(NREG)) u_wdec (
    .idx    (waddr),
    .en     (wr_en),
    .strobe (wstb)
  );

  dec4_to_16 #(.N(NREG)) u_cdec (
    .idx    (cidx),
    .en     (clr_en),
    .strobe (cstb)
  );

  // r0 has no storage, so its strobes go nowhere.
  assign unused_strobes = wstb[0] | cstb[0];

  // Clear controller: cidx walks 1..NREG-1, terminal step returns to IDLE.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      cidx     <= '0;
      busy     <= 1'b0;
      clr_done <= 1'b0;
    end else begin
      clr_done <= 1'b0;
      case (state)
        IDLE: begin
          if (clr_req) begin
            state <= CLEAR;
            cidx  <= ADDR_WIDTH'(1);
            busy  <= 1'b1;
          end
        end
        CLEAR: begin
          if (cidx == ADDR_WIDTH'(NREG - 1)) begin
            state    <= IDLE;
            cidx     <= '0;
            busy     <= 1'b0;
            clr_done <= 1'b1;
          end else begin
            cidx <= cidx + ADDR_WIDTH'(1);
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  // Storage flops r1..r15; clear strobe and write strobe are never both high.
  for (genvar i = 1; i < int'(NREG); i++) begin : g_reg
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        r[i] <= '0;
      end else if (cstb[i]) begin
        r[i] <= '0;
      end else if (wstb[i]) begin
        r[i] <= wdata;
      end
    end
  end

  assign q0  = '0;
  assign q1  = r[1];
  assign q2  = r[2];
  assign q3  = r[3];
  assign q4  = r[4];
  assign q5  = r[5];
  assign q6  = r[6];
  assign q7  = r[7];
  assign q8  = r[8];
  assign q9  = r[9];
  assign q10 = r[10];
  assign q11 = r[11];
  assign q12 = r[12];
  assign q13 = r[13];
  assign q14 = r[14];
  assign q15 = r[15];

endmodule

// File: tb/tb_reg_bank16.sv
// Self-checking bench for reg_bank16: behavioural model checked every cycle
// plus directed literal expectations.
module tb_reg_bank16;

  logic        clk;
  logic        rst;
  logic        we;
  logic [3:0]  waddr;
  logic [31:0] wdata;
  logic        clr_req;
  logic        busy;
  logic        clr_done;
  logic [31:0] q [16];

  int total = 0;
  int bad   = 0;

  // Model: bank contents, clear progress (0 = idle, else next register to zero).
  logic [31:0] m [16];
  int          mnext;
  logic        mdone;

  reg_bank16 dut (
    .clk(clk), .rst(rst), .we(we), .waddr(waddr), .wdata(wdata),
    .clr_req(clr_req), .busy(busy), .clr_done(clr_done),
    .q0(q[0]), .q1(q[1]), .q2(q[2]), .q3(q[3]),
    .q4(q[4]), .q5(q[5]), .q6(q[6]), .q7(q[7]),
    .q8(q[8]), .q9(q[9]), .q10(q[10]), .q11(q[11]),
    .q12(q[12]), .q13(q[13]), .q14(q[14]), .q15(q[15])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  // Behavioural model of the bank.
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 16; i++) m[i] <= '0;
      mnext <= 0;
      mdone <= 1'b0;
    end else begin
      mdone <= 1'b0;
      if (mnext == 0) begin
        if (we && waddr != 4'd0) m[waddr] <= wdata;
        if (clr_req) mnext <= 1;
      end else begin
        m[mnext] <= '0;
        if (mnext == 15) begin
          mnext <= 0;
          mdone <= 1'b1;
        end else begin
          mnext <= mnext + 1;
        end
      end
    end
  end

  // Every-cycle comparison against the model.
  always @(negedge clk) begin
    if (!rst) begin
      for (int i = 0; i < 16; i++) chk($sformatf("model_q%0d", i), q[i], m[i]);
      chk("model_busy", 32'(busy), 32'(mnext != 0));
      chk("model_done", 32'(clr_done), 32'(mdone));
    end
  end

  task automatic wr(input logic [3:0] a, input logic [31:0] d);
    we = 1'b1; waddr = a; wdata = d;
    @(negedge clk);
    we = 1'b0;
  endtask

  initial begin
    #100000;
    bad++;
    $display("FAIL watchdog actual=timeout required=finish");
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    int nb;
    int nd;
    we = 1'b0; waddr = '0; wdata = '0; clr_req = 1'b0;
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("rst_q5", q[5], 32'h0);
    chk("rst_busy", 32'(busy), 32'h0);
    chk("rst_done", 32'(clr_done), 32'h0);

    // Basic write, then write to r0.
    wr(4'd5, 32'hDEADBEEF);
    chk("wr_q5", q[5], 32'hDEADBEEF);
    chk("wr_q4", q[4], 32'h0);
    chk("wr_q6", q[6], 32'h0);
    wr(4'd0, 32'hFFFFFFFF);
    chk("wr_q0", q[0], 32'h0);

    // Fill and clear, checking each register as it is zeroed.
    for (int i = 1; i < 16; i++) wr(4'(i), 32'h11111111 * 32'(i));
    chk("fill_q15", q[15], 32'hFFFFFFFF);
    clr_req = 1'b1;
    @(negedge clk);
    clr_req = 1'b0;
    nb = busy ? 1 : 0;
    nd = 0;
    chk("clr_q1_pre", q[1], 32'h11111111);
    for (int k = 1; k <= 15; k++) begin
      @(negedge clk);
      chk($sformatf("clr_edge%0d_qk", k), q[k], 32'h0);
      if (k < 15) chk($sformatf("clr_edge%0d_qnext", k), q[k+1], 32'h11111111 * 32'(k + 1));
      if (busy) nb++;
      if (clr_done) nd++;
    end
    @(negedge clk);
    if (clr_done) nd++;
    chk("clr_busy_len", 32'(nb), 32'd15);
    chk("clr_done_cnt", 32'(nd), 32'd1);

    // Write and second clr_req during CLEAR are dropped.
    clr_req = 1'b1;
    @(negedge clk);
    clr_req = 1'b0;
    nb = busy ? 1 : 0;
    nd = 0;
    repeat (5) @(negedge clk);
    nb += 5;
    we = 1'b1; waddr = 4'd3; wdata = 32'hA5A5A5A5; clr_req = 1'b1;
    @(negedge clk);
    we = 1'b0; clr_req = 1'b0;
    chk("drop_q3", q[3], 32'h0);
    for (int i = 0; i < 20; i++) begin
      if (busy) nb++;
      if (clr_done) nd++;
      @(negedge clk);
    end
    chk("drop_busy_len", 32'(nb), 32'd15);
    chk("drop_done_cnt", 32'(nd), 32'd1);
    chk("drop_q3_after", q[3], 32'h0);

    // Same-edge write and clear request.
    we = 1'b1; waddr = 4'd7; wdata = 32'h12345678; clr_req = 1'b1;
    @(negedge clk);
    we = 1'b0; clr_req = 1'b0;
    chk("same_q7", q[7], 32'h12345678);
    chk("same_busy", 32'(busy), 32'h1);
    for (int k = 1; k <= 15; k++) begin
      @(negedge clk);
      chk($sformatf("same_edge%0d_q7", k), q[7], (k < 7) ? 32'h12345678 : 32'h0);
    end
    chk("same_done", 32'(clr_done), 32'h1);

    // Asynchronous reset mid-clear at cidx=8.
    wr(4'd9, 32'hCAFEF00D);
    wr(4'd12, 32'h00C0FFEE);
    clr_req = 1'b1;
    @(negedge clk);
    clr_req = 1'b0;
    repeat (7) @(negedge clk);
    chk("abort_q9_pre", q[9], 32'hCAFEF00D);
    #2 rst = 1'b1;
    #1;
    chk("abort_q9", q[9], 32'h0);
    chk("abort_q12", q[12], 32'h0);
    chk("abort_busy", 32'(busy), 32'h0);
    chk("abort_done", 32'(clr_done), 32'h0);
    @(negedge clk);
    rst = 1'b0;
    nd = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (clr_done) nd++;
    end
    chk("abort_no_done", 32'(nd), 32'd0);
    wr(4'd4, 32'h0BADF00D);
    chk("post_rst_wr_q4", q[4], 32'h0BADF00D);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
